car_plant_model: RTL

Closed-loop vehicle/environment model: the responder side of the speed-control FSM interface. It consumes the controller's accelerate_car and unlock_door commands and produces the car_speed and leading_distance sensor values the controller reads. It integrates speed and gap on a prescaled tick, detects collisions, and lets benches and emulation close the loop around the controller.

---
 rtl/car_pkg.sv | 36 +++
 rtl/car_plant_model_if.sv | 25 ++
 rtl/car_plant_model_tick_prescaler.sv | 30 +++
 rtl/car_plant_model.sv | 136 +++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared definitions for the car plant model and its speed controller:
// state encoding, the controller's minimum safe gap, default physics
// constants and the gap clamp helper.
package car_pkg;

  typedef enum logic [1:0] {
    PARKED  = 2'd0,
    DRIVING = 2'd1,
    CRASHED = 2'd2
  } car_state_e;

  localparam int unsigned SPEED_W = 8;
  localparam int unsigned DIST_W  = 7;

  // Minimum safe gap used by the controller.
  localparam logic [DIST_W-1:0]  MIN_DISTANCE = 7'd40;

  localparam int unsigned        DEF_TICK_DIV   = 4;
  localparam logic [SPEED_W-1:0] DEF_ACCEL_STEP = 8'd10;
  localparam logic [SPEED_W-1:0] DEF_DECEL_STEP = 8'd20;
  localparam logic [SPEED_W-1:0] DEF_MAX_SPEED  = 8'd200;
  localparam int unsigned        DEF_DIST_SHIFT = 3;
  localparam logic [DIST_W-1:0]  DEF_INIT_DIST  = 7'd100;

  // Clamp a signed gap sum into the 7-bit range [0,127].
  function automatic logic [DIST_W-1:0] clamp_gap(input logic signed [9:0] sum);
    if (sum < 10'sd0) begin
      return 7'd0;
    end else if (sum > 10'sd127) begin
      return 7'd127;
    end else begin
      return sum[DIST_W-1:0];
    end
  endfunction

endpackage

// File: rtl/car_plant_model_if.sv
// Controller <-> plant bus.
//   master: controller side (drives commands, lead speed, load controls)
//   slave : plant side (drives speed, gap, tick, moving, collision)
interface car_plant_model_if;
  logic       accelerate_car;
  logic       unlock_door;
  logic [7:0] lead_speed;
  logic       load;
  logic [6:0] init_distance;
  logic [7:0] car_speed;
  logic [6:0] leading_distance;
  logic       tick;
  logic       moving;
  logic       collision;

  modport master (
    output accelerate_car, unlock_door, lead_speed, load, init_distance,
    input  car_speed, leading_distance, tick, moving, collision
  );

  modport slave (
    input  accelerate_car, unlock_door, lead_speed, load, init_distance,
    output car_speed, leading_distance, tick, moving, collision
  );
endinterface

// File: rtl/car_plant_model_tick_prescaler.sv
// Physics tick prescaler: counts 0..TICK_DIV-1 and wraps.
//   clk, rst (async active-low), clear (restart count at 0)
//   update_c: high during the cycle whose closing edge is the update edge
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic update_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign update_c = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Counter; clear has priority so a load restarts a full tick period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || update_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/car_plant_model.sv
// Vehicle/environment model closing the loop around the speed controller.
// Integrates own speed and gap to the leading vehicle once per prescaled
// tick and latches collisions.
//   clk, rst (async active-low)
//   bus (slave): accelerate_car, unlock_door, lead_speed, load,
//                init_distance in; car_speed, leading_distance, tick,
//                moving, collision out (all registered)
module car_plant_model
  import car_pkg::*;
#(
  parameter int unsigned        TICK_DIV   = DEF_TICK_DIV,
  parameter logic [SPEED_W-1:0] ACCEL_STEP = DEF_ACCEL_STEP,
  parameter logic [SPEED_W-1:0] DECEL_STEP = DEF_DECEL_STEP,
  parameter logic [SPEED_W-1:0] MAX_SPEED  = DEF_MAX_SPEED,
  parameter int unsigned        DIST_SHIFT = DEF_DIST_SHIFT,
  parameter logic [DIST_W-1:0]  INIT_DIST  = DEF_INIT_DIST
) (
  input logic              clk,
  input logic              rst,
  car_plant_model_if.slave bus
);

  car_state_e          state_q, state_d;
  logic [SPEED_W-1:0]  speed_q, speed_d;
  logic [DIST_W-1:0]   gap_q, gap_d;
  logic                tick_q, tick_d;
  logic                moving_q, moving_d;
  logic                coll_q, coll_d;

  logic                update_c;
  logic                load_ok_c;
  logic                go_c;
  logic signed [8:0]   diff_c;
  logic signed [8:0]   delta_c;
  logic signed [9:0]   sum_c;
  logic [DIST_W-1:0]   gap_new_c;
  logic [8:0]          acc_sum_c;
  logic [SPEED_W-1:0]  accel_spd_c;
  logic [SPEED_W-1:0]  brake_spd_c;

  // load only acts when the car is stationary.
  assign load_ok_c = bus.load && (state_q != DRIVING);
  assign go_c      = bus.accelerate_car && !bus.unlock_door;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (load_ok_c),
    .update_c (update_c)
  );

  // Gap integration from relative speed, using the pre-update own speed.
  assign diff_c    = $signed({1'b0, bus.lead_speed}) - $signed({1'b0, speed_q});
  assign delta_c   = diff_c >>> DIST_SHIFT;
  assign sum_c     = $signed({3'b000, gap_q}) + $signed({delta_c[8], delta_c});
  assign gap_new_c = clamp_gap(sum_c);

  // Saturating speed steps; 9-bit sum so the ceiling check cannot wrap.
  assign acc_sum_c   = {1'b0, speed_q} + {1'b0, ACCEL_STEP};
  assign accel_spd_c = (acc_sum_c > {1'b0, MAX_SPEED}) ? MAX_SPEED : acc_sum_c[SPEED_W-1:0];
  assign brake_spd_c = (speed_q > DECEL_STEP) ? (speed_q - DECEL_STEP) : '0;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PARKED;
      speed_q  <= '0;
      gap_q    <= INIT_DIST;
      tick_q   <= 1'b0;
      moving_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      gap_q    <= gap_d;
      tick_q   <= tick_d;
      moving_q <= moving_d;
      coll_q   <= coll_d;
    end
  end

  // Next state and datapath; load beats a coincident update.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    gap_d   = gap_q;
    coll_d  = coll_q;
    tick_d  = 1'b0;

    if (load_ok_c) begin
      state_d = PARKED;
      speed_d = '0;
      gap_d   = bus.init_distance;
      coll_d  = 1'b0;
    end else if (update_c) begin
      tick_d = 1'b1;
      case (state_q)
        PARKED: begin
          gap_d = gap_new_c;
          if (go_c) begin
            state_d = DRIVING;
            speed_d = ACCEL_STEP;
          end
        end
        DRIVING: begin
          gap_d   = gap_new_c;
          speed_d = go_c ? accel_spd_c : brake_spd_c;
          // Crash takes priority over coming to rest.
          if ((gap_new_c == '0) && (speed_d != '0)) begin
            state_d = CRASHED;
            speed_d = '0;
            coll_d  = 1'b1;
          end else if (speed_d == '0) begin
            state_d = PARKED;
          end
        end
        CRASHED: begin
          speed_d = '0;
        end
        default: begin
          state_d = PARKED;
          speed_d = '0;
        end
      endcase
    end

    moving_d = (state_d == DRIVING);
  end

  assign bus.car_speed        = speed_q;
  assign bus.leading_distance = gap_q;
  assign bus.tick             = tick_q;
  assign bus.moving           = moving_q;
  assign bus.collision        = coll_q;

endmodule
